// File: rtl/spi_slave_responder.sv
// SPI mode-0 slave: oversampled sclk/mosi/chip_select, MSB first, one-entry tx buffer.
// Optional frame_err output when SPI_SLAVE_FRAME_ERR_EN is defined.
module spi_slave_responder #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  chip_select,
  output logic                  miso,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ack,
  output logic                  overrun,
  output logic                  busy
`ifdef SPI_SLAVE_FRAME_ERR_EN
  ,
  output logic                  frame_err
`endif
);

  localparam int unsigned CntWidth = $clog2(DATA_WIDTH);
  localparam logic [CntWidth-1:0] LastBit = CntWidth'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {StWaitIdle, StIdle, StShift} state_e;

  state_e                state;
  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, cs_sync;
  logic                  sclk_prev, cs_prev;
  logic                  buf_full;
  logic [DATA_WIDTH-1:0] buf_data;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-2:0] rx_shift;
  logic [CntWidth-1:0]   bit_cnt;

  logic                  sclk_s, mosi_s, cs_s;
  logic                  sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic                  tx_fire, consume, byte_done, frame_abort;
  logic [DATA_WIDTH-1:0] next_tx, rx_next;

  // cs chain resets low so a reset taken mid-frame waits for a real deselect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_sync   <= '0;
      sclk_prev <= 1'b0;
      cs_prev   <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], chip_select};
      sclk_prev <= sclk_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
    end
  end

  always_comb begin
    sclk_s      = sclk_sync[SYNC_STAGES-1];
    mosi_s      = mosi_sync[SYNC_STAGES-1];
    cs_s        = cs_sync[SYNC_STAGES-1];
    sclk_rise   = sclk_s & ~sclk_prev;
    sclk_fall   = ~sclk_s & sclk_prev;
    cs_rise     = cs_s & ~cs_prev;
    cs_fall     = ~cs_s & cs_prev;
    tx_fire     = tx_valid & ~buf_full;
    next_tx     = buf_full ? buf_data : (tx_fire ? tx_data : '0);
    rx_next     = {rx_shift, mosi_s};
    frame_abort = (state == StShift) && cs_rise;
    byte_done   = (state == StShift) && !cs_rise && sclk_rise && (bit_cnt == LastBit);
    // The falling edge after a completed byte presents the next byte's MSB
    consume     = ((state == StIdle) && cs_fall) ||
                  ((state == StShift) && !cs_rise && sclk_fall && (bit_cnt == '0));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StWaitIdle;
      buf_full <= 1'b0;
      buf_data <= '0;
      tx_shift <= '0;
      rx_shift <= '0;
      bit_cnt  <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      overrun  <= 1'b0;
`ifdef SPI_SLAVE_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
    end else begin
      if (consume) begin
        buf_full <= 1'b0;
      end else if (tx_fire) begin
        buf_full <= 1'b1;
        buf_data <= tx_data;
      end

      if (byte_done) begin
        rx_data  <= rx_next;
        rx_valid <= 1'b1;
        if (rx_valid && !rx_ack) overrun <= 1'b1;
      end else if (rx_ack && rx_valid) begin
        rx_valid <= 1'b0;
        overrun  <= 1'b0;
      end

`ifdef SPI_SLAVE_FRAME_ERR_EN
      if (frame_abort && (bit_cnt != '0)) frame_err <= 1'b1;
      else if (rx_ack)                    frame_err <= 1'b0;
`endif

      case (state)
        StWaitIdle: if (cs_s) state <= StIdle;
        StIdle: begin
          if (cs_fall) begin
            state    <= StShift;
            tx_shift <= next_tx;
            bit_cnt  <= '0;
          end
        end
        StShift: begin
          if (frame_abort) begin
            state <= StIdle;
          end else if (sclk_rise) begin
            rx_shift <= rx_next[DATA_WIDTH-2:0];
            bit_cnt  <= (bit_cnt == LastBit) ? '0 : bit_cnt + CntWidth'(1);
          end else if (sclk_fall) begin
            tx_shift <= (bit_cnt == '0) ? next_tx : {tx_shift[DATA_WIDTH-2:0], 1'b0};
          end
        end
        default: state <= StWaitIdle;
      endcase
    end
  end

  assign tx_ready = ~buf_full;
  assign busy     = (state == StShift);
  assign miso     = (state == StShift) & tx_shift[DATA_WIDTH-1];

endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: bench-side SPI master at clk/8 with
// scoreboard queues for bytes the master should receive and bytes the slave should deliver.
module tb_spi_slave_responder;

  logic       clk = 1'b0;
  logic       rst, sclk, mosi, chip_select, miso;
  logic [7:0] tx_data, rx_data, got;
  logic       tx_valid, tx_ready, rx_valid, rx_ack, overrun, busy;
`ifdef SPI_SLAVE_FRAME_ERR_EN
  logic       frame_err;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] miso_exp[$];
  logic auto_ack = 1'b0;
  logic auto_pulse = 1'b0;
  logic ack_req = 1'b0;

  assign rx_ack = ack_req | auto_pulse;

  always #5 clk = ~clk;

  spi_slave_responder #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .sclk        (sclk),
    .mosi        (mosi),
    .chip_select (chip_select),
    .miso        (miso),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ack      (rx_ack),
    .overrun     (overrun),
    .busy        (busy)
`ifdef SPI_SLAVE_FRAME_ERR_EN
    ,
    .frame_err   (frame_err)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Consumer model: acknowledges each delivered byte and scores it
  always @(negedge clk) begin
    if (auto_ack && rx_valid && !auto_pulse) begin
      check("rx_expected_pending", 32'(rx_exp.size() != 0), 1);
      if (rx_exp.size() != 0) check("rx_data_scoreboard", rx_data, rx_exp.pop_front());
      auto_pulse <= 1'b1;
    end else begin
      auto_pulse <= 1'b0;
    end
  end

  task automatic check_reset_values();
    check("rst_miso", miso, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_rx_data", rx_data, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("rst_frame_err", frame_err, 0);
`endif
  endtask

  task automatic spi_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
    mi = '0;
    for (int i = 0; i < nbits; i++) begin
      mosi = mo[7-i];
      repeat (4) @(negedge clk);
      sclk = 1'b1;
      mi = {mi[6:0], miso};
      repeat (4) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] mo);
    logic [7:0] mi;
    spi_bits(mo, 8, mi);
    check("miso_byte", mi, miso_exp.pop_front());
  endtask

  task automatic cs_low();
    chip_select = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic cs_high();
    repeat (4) @(negedge clk);
    chip_select = 1'b1;
    mosi = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic push_tx(input logic [7:0] d);
    int n = 0;
    while (!tx_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("tx_ready_wait", tx_ready, 1);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("tx_ready_drop", tx_ready, 0);
  endtask

  task automatic ack_pulse();
    ack_req = 1'b1;
    @(negedge clk);
    ack_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; chip_select = 1'b1; sclk = 1'b0; mosi = 1'b0;
    tx_data = '0; tx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // Single-byte frame with preloaded response
    auto_ack = 1'b1;
    push_tx(8'h22);
    miso_exp.push_back(8'h22);
    rx_exp.push_back(8'h11);
    cs_low();
    check("busy_in_frame", busy, 1);
    xfer(8'h11);
    cs_high();
    check("t1_rx_drained", rx_exp.size(), 0);
    check("t1_rx_data", rx_data, 8'h11);
    check("t1_busy_after", busy, 0);

    // Two-byte frame, buffer refilled mid-frame
    push_tx(8'hA5);
    miso_exp.push_back(8'hA5); miso_exp.push_back(8'h3C);
    rx_exp.push_back(8'h0A); rx_exp.push_back(8'h01);
    cs_low();
    check("t2_tx_ready_after_load", tx_ready, 1);
    push_tx(8'h3C);
    xfer(8'h0A);
    xfer(8'h01);
    cs_high();
    check("t2_rx_drained", rx_exp.size(), 0);
    check("t2_overrun", overrun, 0);

    // Empty buffer underrun returns zero
    check("t3_tx_ready", tx_ready, 1);
    miso_exp.push_back(8'h00);
    rx_exp.push_back(8'hFF);
    cs_low();
    xfer(8'hFF);
    cs_high();
    check("t3_rx_drained", rx_exp.size(), 0);
    check("t3_rx_data", rx_data, 8'hFF);

    // Overrun: two bytes without acknowledge
    auto_ack = 1'b0;
    miso_exp.push_back(8'h00); miso_exp.push_back(8'h00);
    cs_low();
    xfer(8'h33);
    xfer(8'hC4);
    cs_high();
    check("t4_rx_valid", rx_valid, 1);
    check("t4_rx_data", rx_data, 8'hC4);
    check("t4_overrun", overrun, 1);
    ack_pulse();
    check("t4_rx_valid_cleared", rx_valid, 0);
    check("t4_overrun_cleared", overrun, 0);

    // Partial frame is dropped
    auto_ack = 1'b1;
    cs_low();
    spi_bits(8'hA0, 3, got);
    cs_high();
    check("t5_rx_valid", rx_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_rx_data_kept", rx_data, 8'hC4);
`ifdef SPI_SLAVE_FRAME_ERR_EN
    check("t5_frame_err", frame_err, 1);
    ack_pulse();
    check("t5_frame_err_cleared", frame_err, 0);
`endif

    // Reset mid-byte, rest of frame ignored, then a clean frame
    cs_low();
    spi_bits(8'hF0, 4, got);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_values();
    rst = 1'b0;
    spi_bits(8'h0F, 4, got);
    cs_high();
    check("t6_rx_valid_ignored", rx_valid, 0);
    check("t6_busy", busy, 0);
    miso_exp.push_back(8'h00);
    rx_exp.push_back(8'h5A);
    cs_low();
    xfer(8'h5A);
    cs_high();
    check("t6_rx_drained", rx_exp.size(), 0);
    check("t6_rx_data", rx_data, 8'h5A);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
